neural_unit_sequencer: RTL and testbench

- Initiator/controller for a 4-input neural unit. It sits on the other end of the unit's weight-write, sum-trigger and layer-done interface.
- Accepts a stream of 8-bit weights over a valid/ready handshake and writes them to weight addresses 0..3.
- Pulses the sum trigger with the selected layer mode, then waits for layer-done with a timeout.
- Captures the 32-bit layer output and presents it on a valid/ready result port for the next layer or the host.

---
 rtl/neural_unit_sequencer.sv | 144 ++++++++++++++
 tb/tb_neural_unit_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neural_unit_sequencer.sv
`default_nettype none
// neural_unit_sequencer: streams 4 weights into a neural unit, fires its sum trigger,
// waits for layer-done under a timeout and offers the captured result on valid/ready.
module neural_unit_sequencer #(
  parameter int NUM_W          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              reload,
  input  logic              layer_sel,
  input  logic [7:0]        weight_in,
  input  logic              weight_valid,
  output logic              weight_ready,
  output logic [7:0]        nu_weight,
  output logic [1:0]        nu_address,
  output logic              nu_write,
  output logic              nu_sumTrigger,
  output logic              nu_layer_Sel,
  input  logic [DATA_W-1:0] nu_layerOut,
  input  logic              nu_layerDone,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    TRIGGER = 3'd2,
    WAIT    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [1:0]  BEAT_LAST = 2'(NUM_W - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t              state_q;
  logic [1:0]          beat_q;
  logic [15:0]         wait_q;
  logic                defer_q;
  logic                sel_q;
  logic [7:0]          weight_q;
  logic [1:0]          addr_q;
  logic                write_q;
  logic                trig_q;
  logic [DATA_W-1:0]   result_q;
  logic                valid_q;
  logic                err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      wait_q   <= 16'd0;
      defer_q  <= 1'b0;
      sel_q    <= 1'b0;
      weight_q <= 8'd0;
      addr_q   <= 2'd0;
      write_q  <= 1'b0;
      trig_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      write_q <= 1'b0;
      trig_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q  <= layer_sel;
            err_q  <= 1'b0;
            beat_q <= 2'd0;
            if (reload) begin
              state_q <= LOAD;
            end else begin
              state_q <= TRIGGER;
              defer_q <= 1'b0;
              trig_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (weight_valid) begin
            weight_q <= weight_in;
            addr_q   <= beat_q;
            write_q  <= 1'b1;
            beat_q   <= beat_q + 2'd1;
            // Last beat: its write lands in a quiet TRIGGER cycle ahead of the pulse.
            if (beat_q == BEAT_LAST) begin
              state_q <= TRIGGER;
              defer_q <= 1'b1;
            end
          end
        end
        TRIGGER: begin
          if (defer_q) begin
            defer_q <= 1'b0;
            trig_q  <= 1'b1;
          end else begin
            state_q <= WAIT;
            wait_q  <= 16'd0;
          end
        end
        WAIT: begin
          wait_q <= wait_q + 16'd1;
          // wait_q == 0 is the first WAIT cycle, where a stale done is blanked.
          if (nu_layerDone && (wait_q != 16'd0)) begin
            result_q <= nu_layerOut;
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end else if (wait_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign weight_ready  = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign nu_weight     = weight_q;
  assign nu_address    = addr_q;
  assign nu_write      = write_q;
  assign nu_sumTrigger = trig_q;
  assign nu_layer_Sel  = sel_q;
  assign result        = result_q;
  assign result_valid  = valid_q;
  assign timeout_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_neural_unit_sequencer.sv
`default_nettype none
// Bench for neural_unit_sequencer: directed operation table plus randomized operations,
// every cycle compared against a transaction-level timing model.
module tb_neural_unit_sequencer;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int N  = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, reload, layer_sel, weight_valid, result_ready, nu_layerDone;
  logic [7:0]    weight_in;
  logic [DW-1:0] nu_layerOut;
  logic          weight_ready, nu_write, nu_sumTrigger, nu_layer_Sel, result_valid, busy, timeout_err;
  logic [7:0]    nu_weight;
  logic [1:0]    nu_address;
  logic [DW-1:0] result;

  neural_unit_sequencer #(.NUM_W(4), .TIMEOUT_CYCLES(TO), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .reload(reload), .layer_sel(layer_sel),
    .weight_in(weight_in), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .nu_weight(nu_weight), .nu_address(nu_address), .nu_write(nu_write),
    .nu_sumTrigger(nu_sumTrigger), .nu_layer_Sel(nu_layer_Sel), .nu_layerOut(nu_layerOut),
    .nu_layerDone(nu_layerDone), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // Architectural state the model carries between operations
  logic [7:0]    m_wdata;
  logic [1:0]    m_addr;
  logic          m_sel;
  logic [DW-1:0] m_res;
  logic          m_err;

  // Per-operation stimulus schedule, indexed by cycle relative to the start cycle
  logic          s_wv[N];
  logic          s_done[N];
  logic          s_rdy[N];
  logic          s_start[N];
  logic [7:0]    s_win[N];
  logic [DW-1:0] s_lo[N];

  int obs_trig;
  int obs_writes;

  typedef struct {
    logic          reload;
    logic          sel;
    logic          hold_start;
    logic [63:0]   wv;
    logic [63:0]   done;
    logic [63:0]   rdy;
    logic [DW-1:0] lo;
    int            exp_trig;
    int            exp_writes;
    logic [DW-1:0] exp_res;
    logic          exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, int r, logic e_busy, logic e_wr, logic e_write,
                       logic e_trig, logic e_rv);
    logic [48:0] act;
    logic [48:0] exp;
    act = {busy, weight_ready, nu_write, nu_address, nu_weight, nu_sumTrigger,
           nu_layer_Sel, result_valid, timeout_err, result};
    exp = {e_busy, e_wr, e_write, m_addr, m_wdata, e_trig, m_sel, e_rv, m_err, m_res};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d outputs got %h expected %h", tag, r, act, exp);
    end
  endtask

  task automatic check_val(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_zero(string tag);
    logic [48:0] act;
    act = {busy, weight_ready, nu_write, nu_address, nu_weight, nu_sumTrigger,
           nu_layer_Sel, result_valid, timeout_err, result};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s outputs got %h expected 0", tag, act);
    end
  endtask

  task automatic idle(string tag, int n);
    for (int r = 0; r < n; r++) begin
      check(tag, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      start        = 1'b0;
      reload       = 1'($urandom);
      layer_sel    = 1'($urandom);
      weight_valid = 1'($urandom);
      weight_in    = 8'($urandom);
      nu_layerDone = 1'($urandom);
      nu_layerOut  = $urandom;
      result_ready = 1'($urandom);
      tick();
    end
  endtask

  // Derives the expected event timeline of one operation from the schedule, then
  // drives it while comparing all outputs every cycle.
  task automatic run_op(string tag, logic rl, logic sel);
    int c4, t, hv, h, e, nb;
    logic ok, wflag;
    logic [DW-1:0] cap;
    logic [7:0] wd[4];
    int wc[4];
    c4 = 0; nb = 0; ok = 1'b0; hv = 0; h = 0; cap = '0;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 8'd0;
      wc[i] = -1;
    end
    if (rl) begin
      for (int r = 1; r < N; r++) begin
        if (nb < 4 && s_wv[r]) begin
          wd[nb] = s_win[r];
          wc[nb] = r + 1;
          c4 = r;
          nb++;
        end
      end
      t = c4 + 2;
    end else begin
      t = 1;
    end
    for (int n = 2; n <= TO; n++) begin
      if (!ok && s_done[t+n]) begin
        ok  = 1'b1;
        hv  = t + n + 1;
        cap = s_lo[t+n];
      end
    end
    if (ok) begin
      h = hv;
      while (h < N - 1 && !s_rdy[h]) h++;
      e = h + 1;
    end else begin
      e = t + TO + 1;
    end
    obs_trig   = -1;
    obs_writes = 0;
    for (int r = 0; r < e; r++) begin
      if (r == 1) begin
        m_sel = sel;
        m_err = 1'b0;
      end
      wflag = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (r == wc[i]) begin
          wflag   = 1'b1;
          m_wdata = wd[i];
          m_addr  = 2'(i);
        end
      end
      if (ok && r == hv) m_res = cap;
      check(tag, r, r >= 1, rl && r >= 1 && r <= c4, wflag, r == t, ok && r >= hv && r <= h);
      if (nu_sumTrigger && obs_trig < 0) obs_trig = r;
      if (nu_write) obs_writes++;
      start        = (r == 0) ? 1'b1 : s_start[r];
      reload       = (r == 0) ? rl : 1'($urandom);
      layer_sel    = (r == 0) ? sel : 1'($urandom);
      weight_valid = s_wv[r];
      weight_in    = s_win[r];
      nu_layerDone = s_done[r];
      nu_layerOut  = s_lo[r];
      result_ready = s_rdy[r];
      tick();
    end
    m_err = !ok;
  endtask

  task automatic run_vec(int k);
    for (int r = 0; r < N; r++) begin
      if (r < 64) begin
        s_wv[r]   = tbl[k].wv[r];
        s_done[r] = tbl[k].done[r];
        s_rdy[r]  = tbl[k].rdy[r];
      end else begin
        s_wv[r]   = 1'b1;
        s_done[r] = 1'b0;
        s_rdy[r]  = 1'b1;
      end
      s_win[r]   = 8'(r);
      s_lo[r]    = tbl[k].lo;
      s_start[r] = tbl[k].hold_start;
    end
    run_op($sformatf("vec%0d", k), tbl[k].reload, tbl[k].sel);
    check_val($sformatf("vec%0d trigger cycle", k), obs_trig, tbl[k].exp_trig);
    check_val($sformatf("vec%0d write count", k), obs_writes, tbl[k].exp_writes);
    check_val($sformatf("vec%0d result", k), result, tbl[k].exp_res);
    check_val($sformatf("vec%0d timeout_err", k), {31'd0, timeout_err}, {31'd0, tbl[k].exp_err});
  endtask

  task automatic run_rand();
    int pd;
    pd = $urandom_range(0, 3);
    for (int r = 0; r < N; r++) begin
      s_wv[r]    = (r >= 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
      s_win[r]   = 8'($urandom);
      s_done[r]  = (pd == 0) ? 1'b0 : ($urandom_range(0, 7) < pd);
      s_rdy[r]   = (r >= 40) ? 1'b1 : 1'($urandom);
      s_lo[r]    = $urandom;
      s_start[r] = 1'($urandom);
    end
    run_op("rand", 1'($urandom), 1'($urandom));
    if ($urandom_range(0, 1) == 1) idle("gap", $urandom_range(1, 3));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; reload = 1'b0; layer_sel = 1'b0;
    weight_valid = 1'b0; weight_in = 8'd0; nu_layerDone = 1'b0;
    nu_layerOut = '0; result_ready = 1'b0;
    m_wdata = 8'd0; m_addr = 2'd0; m_sel = 1'b0; m_res = '0; m_err = 1'b0;

    //           rl    sel   hold  wv                     done          rdy                    lo            trig wr res           err
    tbl[0] = '{1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h200,      64'hFFFF_FFFF_FFFF_F000, 32'h0000_00AA, 6, 4, 32'h0000_00AA, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h800,      64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0055, 9, 4, 32'h0000_0055, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8,        64'hFFFF_FFFF_FFFF_FF00, 32'h1234_5678, 1, 0, 32'h1234_5678, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 64'h0,                   64'h0,        64'hFFFF_FFFF_FFFF_FFFF, 32'hDEAD_0001, 1, 0, 32'h1234_5678, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 64'h0,                   64'h200,      64'hFFFF_FFFF_FFFF_FFFF, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 64'h0,                   64'h7,        64'hFFFF_FFFF_FFFF_FFFF, 32'h5555_5555, 1, 0, 32'hCAFE_F00D, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0BAD_BEEF, 1, 0, 32'h0BAD_BEEF, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100,      64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 6, 4, 32'hFFFF_FFFF, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset state");
    #2 reset = 1'b1;
    tick();
    idle("idle", 2);

    for (int k = 0; k < 8; k++) run_vec(k);
    idle("idle", 1);

    // Abort a load after two beats with an asynchronous reset
    start = 1'b1; reload = 1'b1; layer_sel = 1'b1; weight_valid = 1'b1; weight_in = 8'h5A;
    tick();
    start = 1'b0; weight_in = 8'h5B;
    tick();
    weight_in = 8'h5C;
    tick();
    check_val("abort pre-reset write", {21'd0, nu_write, nu_address, nu_weight}, {21'd0, 1'b1, 2'd1, 8'h5C});
    #2 reset = 1'b0;
    #1 check_zero("async reset");
    @(posedge clk);
    #1 check_zero("reset held");
    #2 reset = 1'b1;
    m_wdata = 8'd0; m_addr = 2'd0; m_sel = 1'b0; m_res = '0; m_err = 1'b0;
    idle("post reset", 3);
    run_vec(0);

    for (int i = 0; i < 30; i++) run_rand();
    idle("final", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
